// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//
// Shares the single register-file write port between the in-order WB stage
// of the 5-stage MIPS pipeline and one auxiliary long-latency requester
// (multi-cycle mult/div, slow load return). It selects the WB result
// (ALU / memory / zero) and registers the final write.
//
// The WB stage normally has priority. A starvation guard counts consecutive
// denied auxiliary cycles; once STARVE_LIMIT of them have gone by, the
// pipeline is frozen for exactly one cycle (FORCE) and the auxiliary request
// is granted. The WB instruction held during that cycle is presented again
// afterwards, so it is ignored while frozen.
//
// Parameters
//   STARVE_LIMIT  denied auxiliary cycles before a FORCE cycle (1..2^CNT_W-1)
//   CNT_W         width of the starvation counter
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   wb_valid      WB-stage instruction writes a register
//   wb_memtoreg   WB select: 00 ALU, 01 memory, 1x zero
//   wb_waddr      WB destination register
//   wb_aluout     WB ALU result
//   wb_memdata    WB memory read data
//   aux_valid     auxiliary write request
//   aux_waddr     auxiliary destination register
//   aux_wdata     auxiliary write data
//   aux_ready     auxiliary request accepted this cycle (combinational)
//   pipe_stall    freeze the pipeline (high only in FORCE)
//   rf_we         register-file write enable (registered)
//   rf_waddr      register-file write address (registered)
//   rf_wdata      register-file write data (registered)
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic [1:0]  wb_memtoreg,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_aluout,
  input  logic [31:0] wb_memdata,
  input  logic        aux_valid,
  input  logic [4:0]  aux_waddr,
  input  logic [31:0] aux_wdata,
  output logic        aux_ready,
  output logic        pipe_stall,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              rf_we_reg, rf_we_next;
  logic [4:0]        rf_waddr_reg, rf_waddr_next;
  logic [31:0]       rf_wdata_reg, rf_wdata_next;

  logic [31:0]       sel_data;
  logic              aux_xfer;
  logic              aux_denied;

  // WB result mux; both 1x encodings yield zero.
  always_comb begin
    sel_data = 32'd0;
    case (wb_memtoreg)
      2'b00:   sel_data = wb_aluout;
      2'b01:   sel_data = wb_memdata;
      default: sel_data = 32'd0;
    endcase
  end

  // Grant: WB wins except in FORCE. Gated by rst_n so nothing is accepted
  // while reset is held (a request granted then would never be written).
  always_comb begin
    aux_ready = 1'b0;
    if (rst_n) begin
      if (state_reg == FORCE) begin
        aux_ready = aux_valid;
      end else begin
        aux_ready = aux_valid && !wb_valid;
      end
    end
  end

  assign aux_xfer   = aux_valid && aux_ready;
  assign aux_denied = aux_valid && !aux_ready;

  // Next state and starvation counter. IDLE and WAIT share one rule: a
  // denied cycle either escalates to FORCE (counter already at LIMIT-1,
  // which covers STARVE_LIMIT = 1 straight from IDLE) or waits; any other
  // cycle means the request transferred or went away.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;

    if (!aux_valid || aux_xfer) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end

    case (state_reg)
      IDLE, WAIT: begin
        if (aux_denied) begin
          state_next = (cnt_reg == LIMIT_M1) ? FORCE : WAIT;
        end else begin
          state_next = IDLE;
        end
      end
      FORCE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Write-port selection. In FORCE the WB stage is frozen and its
  // instruction will be re-presented, so it must not be written now.
  // Writes to $0 still complete the handshake but never assert rf_we.
  always_comb begin
    rf_we_next    = 1'b0;
    rf_waddr_next = rf_waddr_reg;
    rf_wdata_next = rf_wdata_reg;
    if (aux_xfer) begin
      rf_we_next    = (aux_waddr != 5'd0);
      rf_waddr_next = aux_waddr;
      rf_wdata_next = aux_wdata;
    end else if ((state_reg != FORCE) && wb_valid) begin
      rf_we_next    = (wb_waddr != 5'd0);
      rf_waddr_next = wb_waddr;
      rf_wdata_next = sel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      rf_we_reg    <= 1'b0;
      rf_waddr_reg <= 5'd0;
      rf_wdata_reg <= 32'd0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      rf_we_reg    <= rf_we_next;
      rf_waddr_reg <= rf_waddr_next;
      rf_wdata_reg <= rf_wdata_next;
    end
  end

  assign pipe_stall = (state_reg == FORCE);
  assign rf_we      = rf_we_reg;
  assign rf_waddr   = rf_waddr_reg;
  assign rf_wdata   = rf_wdata_reg;

endmodule
